// File: rtl/mult_approx_pkg.sv
// Shared types and constants for the nibble-serial approximate multiplier.
// Mode encoding, FSM states, nibble width and the approximate-partial mask.
package mult_approx_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT      = 2'b00,
    MODE_APPROX_LOW = 2'b01,
    MODE_APPROX_ALL = 2'b10,
    MODE_APPROX_OR  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int NIBBLE = 4;
  localparam logic [7:0] APPROX_MASK = 8'hFC;

endpackage

// File: rtl/approx_mul4x4.sv
// Combinational 4x4 multiplier; when approx is set the two LSBs of the
// product are dropped.
module approx_mul4x4
  import mult_approx_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       approx,
  output logic [7:0] p
);

  logic [7:0] full;

  // Operands are widened first so the product is computed at 8 bits.
  assign full = {4'b0000, a} * {4'b0000, b};
  assign p    = approx ? (full & APPROX_MASK) : full;

endmodule

// File: rtl/mult_nxn_orc_seq.sv
// Sequential WxW multiplier: one 4x4 partial product per cycle through a single
// shared approx_mul4x4, accumulated by add (modes 00/01/10) or OR (mode 11).
module mult_nxn_orc_seq
  import mult_approx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [1:0]     MODE,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] R
);

  localparam int N  = W / NIBBLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = 2 * W;

  generate
    if ((W % NIBBLE) != 0 || W < 8) begin : g_bad_width
      $error("mult_nxn_orc_seq: W must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  mode_e           mode_q;
  logic [CW-1:0]   i_q, j_q;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   term;
  logic [3:0]      nib_a, nib_b;
  logic [7:0]      p;
  logic            approx;
  logic            accept;
  logic            last;
  int              weight;

  assign accept = in_valid && (state_q == ST_IDLE);
  assign last   = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));
  assign weight = int'(i_q) + int'(j_q);

  assign nib_a = a_q[i_q * NIBBLE +: NIBBLE];
  assign nib_b = b_q[j_q * NIBBLE +: NIBBLE];

  always_comb begin
    unique case (mode_q)
      MODE_EXACT:      approx = 1'b0;
      MODE_APPROX_LOW: approx = (weight < N);
      default:         approx = 1'b1;
    endcase
  end

  approx_mul4x4 u_mul (
    .a      (nib_a),
    .b      (nib_b),
    .approx (approx),
    .p      (p)
  );

  assign term = RW'(p) << (NIBBLE * weight);

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CALC;
          acc_d   = '0;
        end
      end
      ST_CALC: begin
        acc_d = (mode_q == MODE_APPROX_OR) ? (acc_q | term) : (acc_q + term);
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_EXACT;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q    <= A;
        b_q    <= B;
        mode_q <= mode_e'(MODE);
        i_q    <= '0;
        j_q    <= '0;
      end else if (state_q == ST_CALC) begin
        // i steps fastest; j advances when i wraps.
        if (i_q == CW'(N - 1)) begin
          i_q <= '0;
          j_q <= (j_q == CW'(N - 1)) ? '0 : j_q + CW'(1);
        end else begin
          i_q <= i_q + CW'(1);
        end
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign R         = acc_q;

endmodule

// File: tb/tb_mult_nxn_orc_seq.sv
// Self-checking bench for mult_nxn_orc_seq at W=8 and W=16 against an
// arithmetic reference model of the nibble-partial accumulation rules.
module tb_mult_nxn_orc_seq;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [1:0]  mode8;
  logic [15:0] r8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [1:0]  mode16;
  logic [31:0] r16;

  int total = 0;
  int bad   = 0;

  mult_nxn_orc_seq #(.W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .A         (a8),
    .B         (b8),
    .MODE      (mode8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .R         (r8)
  );

  mult_nxn_orc_seq #(.W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .A         (a16),
    .B         (b16),
    .MODE      (mode16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .R         (r16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Product built nibble by nibble with plain arithmetic, truncated to 2W bits.
  function automatic logic [31:0] ref_model(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input int mode);
    longint acc = 0;
    int n = w / 4;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < n; i++) begin
        longint an = (a >> (4 * i)) & 15;
        longint bn = (b >> (4 * j)) & 15;
        longint p  = an * bn;
        bit apx = (mode >= 2) || (mode == 1 && (i + j) < n);
        longint t;
        if (apx) p = p - (p % 4);
        t = p << (4 * (i + j));
        if (mode == 3) acc = acc | t;
        else           acc = acc + t;
      end
    end
    acc = acc % (longint'(1) << (2 * w));
    return acc[31:0];
  endfunction

  function automatic logic sel_ir(input bit wide);
    return wide ? in_ready16 : in_ready8;
  endfunction
  function automatic logic sel_ov(input bit wide);
    return wide ? out_valid16 : out_valid8;
  endfunction
  function automatic logic [31:0] sel_r(input bit wide);
    return wide ? r16 : {16'h0, r8};
  endfunction

  task automatic drive(input bit wide, input logic iv, input logic [15:0] a,
                       input logic [15:0] b, input logic [1:0] m);
    if (wide) begin
      in_valid16 = iv; a16 = a; b16 = b; mode16 = m;
    end else begin
      in_valid8 = iv; a8 = a[7:0]; b8 = b[7:0]; mode8 = m;
    end
  endtask

  task automatic set_oready(input bit wide, input logic v);
    if (wide) out_ready16 = v;
    else      out_ready8  = v;
  endtask

  // One operation: accept, scramble inputs, measure latency, check result,
  // optionally stall the consumer for 'hold' cycles, then drain.
  task automatic do_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] mode, input int hold, input string tag);
    logic [31:0] exp_r;
    int lat;
    int np;
    np    = wide ? 16 : 4;
    exp_r = ref_model(wide ? 16 : 8, a, b, int'(mode));
    @(negedge clk);
    check({tag, "_ready_before"}, sel_ir(wide), 1);
    drive(wide, 1'b1, a, b, mode);
    set_oready(wide, hold == 0);
    @(posedge clk);
    #1;
    drive(wide, 1'b0, 16'($urandom), 16'($urandom), 2'($urandom));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!sel_ov(wide) && lat < 200);
    check({tag, "_latency"}, lat, np + 1);
    check({tag, "_result"}, sel_r(wide), exp_r);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      drive(wide, 1'b1, 16'($urandom), 16'($urandom), 2'($urandom));
      @(negedge clk);
      check({tag, "_hold_valid"}, sel_ov(wide), 1);
      check({tag, "_hold_r"}, sel_r(wide), exp_r);
      check({tag, "_hold_ready"}, sel_ir(wide), 0);
    end
    if (hold > 0) begin
      drive(wide, 1'b0, 16'h0, 16'h0, 2'b00);
      set_oready(wide, 1'b1);
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    check({tag, "_drain_valid"}, sel_ov(wide), 0);
    check({tag, "_drain_ready"}, sel_ir(wide), 1);
  endtask

  initial begin
    bit spurious;
    int last_acc;
    int accepts;
    logic [15:0] ra, rb;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 2'b00);
    out_ready8  = 1'b1;
    out_ready16 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid8", out_valid8, 0);
    check("rst_r8", r8, 0);
    check("rst_valid16", out_valid16, 0);
    check("rst_r16", r16, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready8", in_ready8, 1);
    check("rst_ready16", in_ready16, 1);

    do_op(1'b0, 16'hFF, 16'hFF, 2'b00, 0, "ff_exact");
    do_op(1'b0, 16'hFF, 16'hFF, 2'b01, 0, "ff_low");
    do_op(1'b0, 16'hFF, 16'hFF, 2'b10, 0, "ff_all");
    do_op(1'b0, 16'hFF, 16'hFF, 2'b11, 0, "ff_or");
    check("ff_or_literal", r8, 16'hEEE0);
    do_op(1'b0, 16'h03, 16'h03, 2'b00, 0, "three_exact");
    do_op(1'b0, 16'h03, 16'h03, 2'b01, 10, "three_low_hold");
    check("three_low_literal", r8, 16'h0008);

    // Pulses ignored during the stall must not have been queued.
    spurious = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid8) spurious = 1'b1;
    end
    check("no_queue", spurious, 0);

    // Reset during the second CALC cycle aborts the operation.
    @(negedge clk);
    drive(1'b0, 1'b1, 16'hAB, 16'hCD, 2'b00);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid8, 0);
    check("abort_r", r8, 0);
    check("abort_ready", in_ready8, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid8) spurious = 1'b1;
    end
    check("abort_no_output", spurious, 0);
    do_op(1'b0, 16'h02, 16'h05, 2'b00, 0, "after_reset");
    check("after_reset_literal", r8, 16'd10);

    // Back-to-back with out_ready high: one accept every NP+2 cycles.
    @(negedge clk);
    out_ready8 = 1'b1;
    drive(1'b0, 1'b1, 16'h37, 16'h5A, 2'b00);
    last_acc = -1;
    accepts  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (in_ready8) begin
        if (last_acc >= 0) check("b2b_interval", c - last_acc, 6);
        last_acc = c;
        accepts++;
      end
      if (out_valid8) check("b2b_result", r8, 16'h37 * 16'h5A);
    end
    check("b2b_progress", accepts >= 4, 1);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    repeat (8) @(negedge clk);

    // W=16 random exact ops, then random approximate modes.
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; end
      do_op(1'b1, ra, rb, 2'b00, 0, "w16_exact");
      check("w16_exact_product", r16, 32'(ra) * 32'(rb));
    end
    for (int k = 0; k < 300; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(1'b1, ra, rb, 2'(1 + (k % 3)), (k % 50 == 0) ? 3 : 0, "w16_approx");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
